// File: rtl/uart_cmd_host_if.sv
// Command, serial TX/RX byte and response signals of the UART command host.
// slave = the host block, master = whatever issues commands and models the serial link.
interface uart_cmd_host_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                    CMD_VLD;
  logic [1:0]              CMD_TYPE;
  logic [ADDR_WIDTH-1:0]   CMD_ADDR;
  logic [DATA_WIDTH-1:0]   CMD_A;
  logic [DATA_WIDTH-1:0]   CMD_B;
  logic [3:0]              CMD_FUN;
  logic                    CMD_RDY;
  logic [DATA_WIDTH-1:0]   TX_DATA;
  logic                    TX_VLD;
  logic                    TX_RDY;
  logic [DATA_WIDTH-1:0]   RX_DATA;
  logic                    RX_VLD;
  logic [2*DATA_WIDTH-1:0] RSP_DATA;
  logic                    RSP_VLD;
  logic                    RSP_TIMEOUT;

  modport master (
    output CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_A, CMD_B, CMD_FUN,
    input  CMD_RDY,
    input  TX_DATA, TX_VLD,
    output TX_RDY,
    output RX_DATA, RX_VLD,
    input  RSP_DATA, RSP_VLD, RSP_TIMEOUT
  );

  modport slave (
    input  CMD_VLD, CMD_TYPE, CMD_ADDR, CMD_A, CMD_B, CMD_FUN,
    output CMD_RDY,
    output TX_DATA, TX_VLD,
    input  TX_RDY,
    input  RX_DATA, RX_VLD,
    output RSP_DATA, RSP_VLD, RSP_TIMEOUT
  );
endinterface

// File: rtl/uart_cmd_host.sv
// Serialises register-file / ALU commands into byte frames and collects the
// 1- or 2-byte response, aborting with a timeout pulse if the link goes quiet.
module uart_cmd_host #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic           CLK,
  input  logic           RST,
  uart_cmd_host_if.slave bus
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] CMD_WR  = 2'b00;
  localparam logic [1:0] CMD_RD  = 2'b01;
  localparam logic [1:0] CMD_OP  = 2'b10;
  localparam logic [1:0] CMD_NOP = 2'b11;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RSP, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [1:0]              type_reg;
  logic [ADDR_WIDTH-1:0]   addr_reg;
  logic [DATA_WIDTH-1:0]   a_reg, b_reg;
  logic [3:0]              fun_reg;
  logic [1:0]              byte_cnt_reg;
  logic                    rsp_idx_reg;
  logic [TW-1:0]           tmo_cnt_reg;
  logic [2*DATA_WIDTH-1:0] rsp_data_reg;

  logic                    cmd_accept, tx_fire, frame_last;
  logic                    rx_accept, rsp_last, tmo_fire;
  logic [1:0]              last_idx;
  logic [DATA_WIDTH-1:0]   frame_byte, addr_ext, fun_ext;
  logic [2*DATA_WIDTH-1:0] rsp_value;
  logic [1:0][DATA_WIDTH-1:0] slot_next;

  assign addr_ext   = DATA_WIDTH'(addr_reg);
  assign fun_ext    = DATA_WIDTH'(fun_reg);
  assign cmd_accept = (state_reg == IDLE) && bus.CMD_VLD;
  assign tx_fire    = (state_reg == SEND) && bus.TX_RDY;
  assign frame_last = tx_fire && (byte_cnt_reg == last_idx);
  assign rx_accept  = (state_reg == WAIT_RSP) && bus.RX_VLD;
  assign rsp_last   = rx_accept && (rsp_idx_reg == (type_reg != CMD_RD));
  // An arriving byte beats the timeout in the cycle the counter expires.
  assign tmo_fire   = (state_reg == WAIT_RSP) && !bus.RX_VLD && (tmo_cnt_reg == TMO_LAST);

  // Frame byte selected from the captured command and the byte counter.
  always_comb begin
    frame_byte = '0;
    last_idx   = 2'd0;
    case (type_reg)
      CMD_WR: begin
        last_idx = 2'd2;
        case (byte_cnt_reg)
          2'd0:    frame_byte = DATA_WIDTH'(8'hAA);
          2'd1:    frame_byte = addr_ext;
          default: frame_byte = a_reg;
        endcase
      end
      CMD_RD: begin
        last_idx   = 2'd1;
        frame_byte = (byte_cnt_reg == 2'd0) ? DATA_WIDTH'(8'hBB) : addr_ext;
      end
      CMD_OP: begin
        last_idx = 2'd3;
        case (byte_cnt_reg)
          2'd0:    frame_byte = DATA_WIDTH'(8'hCC);
          2'd1:    frame_byte = a_reg;
          2'd2:    frame_byte = b_reg;
          default: frame_byte = fun_ext;
        endcase
      end
      default: begin
        last_idx   = 2'd1;
        frame_byte = (byte_cnt_reg == 2'd0) ? DATA_WIDTH'(8'hDD) : fun_ext;
      end
    endcase
  end

  // Response slots, LSB first; slot_next already includes this cycle's byte.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_slot
      logic [DATA_WIDTH-1:0] slot_reg;
      logic                  hit;
      assign hit = rx_accept && (rsp_idx_reg == 1'(gi));
      always_ff @(posedge CLK or negedge RST) begin
        if (!RST)            slot_reg <= '0;
        else if (cmd_accept) slot_reg <= '0;
        else if (hit)        slot_reg <= bus.RX_DATA;
      end
      assign slot_next[gi] = hit ? bus.RX_DATA : slot_reg;
    end
  endgenerate

  always_comb begin
    rsp_value = '0;
    case (type_reg)
      CMD_WR:  rsp_value = '0;
      CMD_RD:  rsp_value = {{DATA_WIDTH{1'b0}}, slot_next[0]};
      default: rsp_value = {slot_next[1], slot_next[0]};
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:     if (cmd_accept) state_next = SEND;
      SEND:     if (frame_last) state_next = (type_reg == CMD_WR) ? DONE : WAIT_RSP;
      WAIT_RSP: begin
        if (rsp_last)      state_next = DONE;
        else if (tmo_fire) state_next = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.CMD_RDY     = (state_reg == IDLE);
    bus.TX_VLD      = (state_reg == SEND);
    bus.TX_DATA     = (state_reg == SEND) ? frame_byte : '0;
    bus.RSP_VLD     = (state_reg == DONE);
    bus.RSP_TIMEOUT = tmo_fire;
    // Partial bytes are visible in the same cycle as the timeout pulse.
    bus.RSP_DATA    = tmo_fire ? rsp_value : rsp_data_reg;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      type_reg     <= CMD_WR;
      addr_reg     <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      fun_reg      <= '0;
      byte_cnt_reg <= 2'd0;
      rsp_idx_reg  <= 1'b0;
      tmo_cnt_reg  <= '0;
      rsp_data_reg <= '0;
    end else begin
      if (cmd_accept) begin
        type_reg     <= bus.CMD_TYPE;
        addr_reg     <= bus.CMD_ADDR;
        a_reg        <= bus.CMD_A;
        b_reg        <= bus.CMD_B;
        fun_reg      <= bus.CMD_FUN;
        byte_cnt_reg <= 2'd0;
        rsp_idx_reg  <= 1'b0;
        tmo_cnt_reg  <= '0;
      end
      if (tx_fire) byte_cnt_reg <= byte_cnt_reg + 2'd1;
      if (frame_last) tmo_cnt_reg <= '0;
      if (state_reg == WAIT_RSP) begin
        if (rx_accept) begin
          rsp_idx_reg <= rsp_idx_reg + 1'b1;
          tmo_cnt_reg <= '0;
        end else begin
          tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
        end
      end
      if ((frame_last && (type_reg == CMD_WR)) || rsp_last || tmo_fire)
        rsp_data_reg <= rsp_value;
    end
  end
endmodule

// File: tb/tb_uart_cmd_host.sv
// Directed bench for uart_cmd_host: TX frames and responses are scoreboarded
// against queues filled when each command is issued.
module tb_uart_cmd_host;
  localparam int T = 16;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  uart_cmd_host_if #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) bus ();

  uart_cmd_host #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .TIMEOUT_CYCLES(T)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [7:0]  tx_q[$];
  bit          rsp_tmo_q[$];
  logic [15:0] rsp_data_q[$];
  int tx_seen, tx_first, tx_last, rsp_seen, rsp_cyc, tmo_seen, tmo_cyc, rx_cyc;
  logic       hold_pending;
  logic [7:0] hold_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic observe();
    cyc++;
    if (bus.TX_VLD) begin
      if (hold_pending) check("tx_hold", 32'(bus.TX_DATA), 32'(hold_val));
      if (bus.TX_RDY) begin
        hold_pending = 1'b0;
        if (tx_q.size() != 0) check("tx_byte", 32'(bus.TX_DATA), 32'(tx_q.pop_front()));
        if (tx_first < 0) tx_first = cyc;
        tx_last = cyc;
        tx_seen++;
      end else begin
        hold_pending = 1'b1;
        hold_val     = bus.TX_DATA;
      end
    end else begin
      hold_pending = 1'b0;
    end
    if (bus.RSP_VLD || bus.RSP_TIMEOUT) begin
      if (bus.RSP_VLD) begin rsp_seen++; rsp_cyc = cyc; end
      if (bus.RSP_TIMEOUT) begin tmo_seen++; tmo_cyc = cyc; end
      if (rsp_data_q.size() != 0) begin
        check("rsp_kind", 32'(bus.RSP_TIMEOUT), 32'(rsp_tmo_q.pop_front()));
        check("rsp_data", 32'(bus.RSP_DATA), 32'(rsp_data_q.pop_front()));
      end
    end
  endtask

  task automatic step(input logic cmd_vld, input logic rdy, input logic rx_vld, input logic [7:0] rx_data);
    @(posedge CLK);
    #1;
    bus.CMD_VLD = cmd_vld;
    bus.TX_RDY  = rdy;
    bus.RX_VLD  = rx_vld;
    bus.RX_DATA = rx_data;
    @(negedge CLK);
    observe();
  endtask

  task automatic issue(input logic [1:0] t, input logic [3:0] addr, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] fun);
    tx_seen = 0; tx_first = -1; rsp_seen = 0; tmo_seen = 0; hold_pending = 1'b0;
    bus.CMD_TYPE = t; bus.CMD_ADDR = addr; bus.CMD_A = a; bus.CMD_B = b; bus.CMD_FUN = fun;
    step(1'b1, 1'b1, 1'b0, 8'h00);
    check("cmd_rdy_issue", 32'(bus.CMD_RDY), 32'd1);
  endtask

  task automatic send_frame(input int n);
    for (int i = 0; i < 12 && tx_seen < n; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    check("tx_count", 32'(tx_seen), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_rdy"}, 32'(bus.CMD_RDY), 32'd1);
    check({tag, "_tx_vld"}, 32'(bus.TX_VLD), 32'd0);
    check({tag, "_tx_data"}, 32'(bus.TX_DATA), 32'd0);
    check({tag, "_rsp_data"}, 32'(bus.RSP_DATA), 32'd0);
    check({tag, "_rsp_vld"}, 32'(bus.RSP_VLD), 32'd0);
    check({tag, "_rsp_tmo"}, 32'(bus.RSP_TIMEOUT), 32'd0);
  endtask

  initial begin
    bus.CMD_VLD = 1'b0; bus.CMD_TYPE = 2'b00; bus.CMD_ADDR = 4'h0; bus.CMD_A = 8'h00;
    bus.CMD_B = 8'h00; bus.CMD_FUN = 4'h0; bus.TX_RDY = 1'b0; bus.RX_VLD = 1'b0; bus.RX_DATA = 8'h00;
    hold_pending = 1'b0; tx_seen = 0; tx_first = -1; tx_last = 0;
    rsp_seen = 0; rsp_cyc = 0; tmo_seen = 0; tmo_cyc = 0; rx_cyc = 0;

    // Reset values
    repeat (3) @(negedge CLK);
    check_reset_outputs("reset");
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);

    // RF write addr 3, A=0x5A, TX_RDY held high
    tx_q.push_back(8'hAA); tx_q.push_back(8'h03); tx_q.push_back(8'h5A);
    rsp_tmo_q.push_back(1'b0); rsp_data_q.push_back(16'h0000);
    issue(2'b00, 4'd3, 8'h5A, 8'h00, 4'h0);
    for (int i = 0; i < 10 && rsp_seen == 0; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    check("wr_tx_count", 32'(tx_seen), 32'd3);
    check("wr_tx_consecutive", 32'(tx_last - tx_first), 32'd2);
    check("wr_rsp_seen", 32'(rsp_seen), 32'd1);
    check("wr_rsp_latency", 32'(rsp_cyc - tx_last), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("wr_cmd_rdy_after", 32'(bus.CMD_RDY), 32'd1);
    check("wr_rsp_single", 32'(bus.RSP_VLD), 32'd0);

    // RX_VLD while idle is ignored
    step(1'b0, 1'b1, 1'b1, 8'h99);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("idle_rx_cmd_rdy", 32'(bus.CMD_RDY), 32'd1);
    check("idle_rx_rsp_data", 32'(bus.RSP_DATA), 32'h0000);
    check("idle_rx_no_rsp", 32'(rsp_seen), 32'd1);

    // RF read addr 2, stray RX during SEND, then response 0x81
    tx_q.push_back(8'hBB); tx_q.push_back(8'h02);
    rsp_tmo_q.push_back(1'b0); rsp_data_q.push_back(16'h0081);
    issue(2'b01, 4'd2, 8'h00, 8'h00, 4'h0);
    step(1'b0, 1'b0, 1'b1, 8'h55);
    send_frame(2);
    repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00);
    check("rd_no_early_rsp", 32'(rsp_seen), 32'd0);
    step(1'b0, 1'b1, 1'b1, 8'h81);
    rx_cyc = cyc;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("rd_rsp_seen", 32'(rsp_seen), 32'd1);
    check("rd_rsp_latency", 32'(rsp_cyc - rx_cyc), 32'd1);

    // ALU op with toggling TX_RDY; CMD_* scrambled and CMD_VLD held during the frame
    tx_q.push_back(8'hCC); tx_q.push_back(8'h10); tx_q.push_back(8'h20); tx_q.push_back(8'h02);
    rsp_tmo_q.push_back(1'b0); rsp_data_q.push_back(16'h0200);
    issue(2'b10, 4'd0, 8'h10, 8'h20, 4'h2);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    bus.CMD_TYPE = 2'b00; bus.CMD_A = 8'hEE; bus.CMD_B = 8'hEF; bus.CMD_FUN = 4'hF;
    for (int i = 1; i < 30 && tx_seen < 4; i++) step(1'b1, 1'(i % 2), 1'b0, 8'h00);
    bus.CMD_VLD = 1'b0;
    check("op_tx_count", 32'(tx_seen), 32'd4);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h02);
    rx_cyc = cyc;
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check("op_rsp_seen", 32'(rsp_seen), 32'd1);
    check("op_rsp_latency", 32'(rsp_cyc - rx_cyc), 32'd1);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("op_tx_extra", 32'(tx_seen), 32'd4);

    // ALU op whose second byte lands exactly on the timeout cycle
    tx_q.push_back(8'hCC); tx_q.push_back(8'h01); tx_q.push_back(8'h02); tx_q.push_back(8'h03);
    rsp_tmo_q.push_back(1'b0); rsp_data_q.push_back(16'hB2A1);
    issue(2'b10, 4'd0, 8'h01, 8'h02, 4'h3);
    send_frame(4);
    step(1'b0, 1'b1, 1'b1, 8'hA1);
    rx_cyc = cyc;
    repeat (T - 1) step(1'b0, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'hB2);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("edge_no_timeout", 32'(tmo_seen), 32'd0);
    check("edge_rsp_seen", 32'(rsp_seen), 32'd1);
    check("edge_rsp_cycle", 32'(rsp_cyc - rx_cyc), 32'(T + 1));

    // ALU nop, only one response byte: timeout T cycles after it
    tx_q.push_back(8'hDD); tx_q.push_back(8'h00);
    rsp_tmo_q.push_back(1'b1); rsp_data_q.push_back(16'h0077);
    issue(2'b11, 4'd0, 8'h00, 8'h00, 4'h0);
    send_frame(2);
    step(1'b0, 1'b1, 1'b1, 8'h77);
    rx_cyc = cyc;
    for (int i = 0; i < T + 5 && tmo_seen == 0; i++) step(1'b0, 1'b1, 1'b0, 8'h00);
    check("nop_tmo_seen", 32'(tmo_seen), 32'd1);
    check("nop_tmo_cycle", 32'(tmo_cyc - rx_cyc), 32'(T));
    check("nop_no_rsp_vld", 32'(rsp_seen), 32'd0);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    check("nop_tmo_single", 32'(bus.RSP_TIMEOUT), 32'd0);
    check("nop_cmd_rdy", 32'(bus.CMD_RDY), 32'd1);
    check("nop_rsp_hold", 32'(bus.RSP_DATA), 32'h0077);

    // Reset during WAIT_RSP, then a late RX byte
    tx_q.push_back(8'hBB); tx_q.push_back(8'h05);
    issue(2'b01, 4'd5, 8'h00, 8'h00, 4'h0);
    send_frame(2);
    repeat (2) step(1'b0, 1'b1, 1'b0, 8'h00);
    @(posedge CLK); #1 RST = 1'b0;
    @(negedge CLK);
    check_reset_outputs("midrst");
    @(posedge CLK); #1 RST = 1'b1;
    @(negedge CLK);
    step(1'b0, 1'b1, 1'b1, 8'hAB);
    repeat (3) step(1'b0, 1'b1, 1'b0, 8'h00);
    check("midrst_no_rsp", 32'(rsp_seen), 32'd0);
    check("midrst_no_tmo", 32'(tmo_seen), 32'd0);
    check_reset_outputs("post_rst");

    check("tx_queue_drained", 32'(tx_q.size()), 32'd0);
    check("rsp_queue_drained", 32'(rsp_data_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
